// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_ctrl
// Purpose  : Sequencing and arbitration controller for a direct-mapped cache
//            (256 lines x 16 words, 20-bit tag, word-granular addressing).
//            Two requesters (port 0 = instruction trace, port 1 = data trace)
//            share one lookup port through round-robin arbitration. A miss
//            refills the whole 16-word line over a word-by-word memory
//            handshake. Hit and miss totals are kept in wrapping counters.
// Ports    : clk, rst_n        - rising-edge clock, async active-low reset
//            req[1:0]          - per-port request, held until done
//            addr0, addr1      - per-port word address
//            grant[1:0]        - one-hot owner of current transaction
//            done, hit         - completion pulse and hit/miss result
//            busy              - controller not idle
//            mem_req, mem_addr - refill word request and word address
//            mem_ack           - memory accepted/returned the current word
//            hit_count         - total hits (wraps)
//            miss_count        - total misses (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        grant,
    output logic              done,
    output logic              hit,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W  = ADDR_W - OFFSET_W;
    localparam int c_LINES = 1 << INDEX_W;
    localparam logic [OFFSET_W-1:0] c_WORD_LAST = {OFFSET_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_REFILL  = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 rr_q, rr_d;
    logic [LINE_W-1:0]    line_q, line_d;
    logic [OFFSET_W-1:0]  word_cnt_q, word_cnt_d;
    logic                 hit_int_q, hit_int_d;
    logic [c_LINES-1:0]   valid_q, valid_d;
    logic [31:0]          hit_count_q, hit_count_d;
    logic [31:0]          miss_count_q, miss_count_d;

    logic [TAG_W-1:0]     tag_mem_q [c_LINES];
    logic                 tag_we;

    logic [INDEX_W-1:0]   w_index;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_lookup_hit;
    logic                 w_sel;

    // Word offset bits of the request addresses are irrelevant: the whole
    // line is refilled and only the line address is latched.
    logic                 w_unused_offset;
    assign w_unused_offset = ^{addr0[OFFSET_W-1:0], addr1[OFFSET_W-1:0]};

    assign w_index      = line_q[INDEX_W-1:0];
    assign w_tag        = line_q[LINE_W-1 -: TAG_W];
    assign w_lookup_hit = valid_q[w_index] && (tag_mem_q[w_index] == w_tag);

    // With both ports requesting, the port not served last wins.
    assign w_sel = (req == 2'b11) ? ~rr_q : req[1];

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        line_d       = line_q;
        word_cnt_d   = word_cnt_q;
        hit_int_d    = hit_int_q;
        valid_d      = valid_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        tag_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    owner_d = w_sel;
                    line_d  = w_sel ? addr1[ADDR_W-1:OFFSET_W]
                                    : addr0[ADDR_W-1:OFFSET_W];
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                hit_int_d  = w_lookup_hit;
                word_cnt_d = '0;
                state_d    = w_lookup_hit ? S_RESPOND : S_REFILL;
            end

            S_REFILL: begin
                if (mem_ack) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    // Tag and valid are committed only on the last word, so an
                    // aborted refill never leaves a half-filled line valid.
                    if (word_cnt_q == c_WORD_LAST) begin
                        tag_we           = 1'b1;
                        valid_d[w_index] = 1'b1;
                        state_d          = S_RESPOND;
                    end
                end
            end

            S_RESPOND: begin
                rr_d = owner_q;
                if (hit_int_q) begin
                    hit_count_d = hit_count_q + 32'd1;
                end else begin
                    miss_count_d = miss_count_q + 32'd1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            rr_q         <= 1'b1;
            line_q       <= '0;
            word_cnt_q   <= '0;
            hit_int_q    <= 1'b0;
            valid_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            line_q       <= line_d;
            word_cnt_q   <= word_cnt_d;
            hit_int_q    <= hit_int_d;
            valid_q      <= valid_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Tag storage needs no reset: its contents are qualified by valid_q.
    // The write strobe depends on the reset state register, so reset
    // during a refill can never commit a tag.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem_q[w_index] <= w_tag;
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state; reset forces them low at once.
    // ------------------------------------------------------------------
    assign busy       = (state_q != S_IDLE);
    assign grant      = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign done       = (state_q == S_RESPOND);
    assign hit        = done && hit_int_q;
    assign mem_req    = (state_q == S_REFILL);
    assign mem_addr   = mem_req ? {line_q, word_cnt_q} : '0;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_cache_ctrl
// Purpose  : Self-checking bench for dm_cache_ctrl. A table of single-port
//            transactions with hand-computed latency, hit flag, refill word
//            count and cumulative counters, followed by hand-written
//            sequences for round-robin, reset mid-refill and same-line
//            contention.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [1:0]  grant;
    logic        done;
    logic        hit;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    dm_cache_ctrl #(
        .ADDR_W   (32),
        .INDEX_W  (8),
        .OFFSET_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .addr0      (addr0),
        .addr1      (addr1),
        .grant      (grant),
        .done       (done),
        .hit        (hit),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] addr;
        int          stall;
        logic        exp_hit;
        int          exp_lat;
        int          exp_words;
        logic [31:0] exp_hc;
        logic [31:0] exp_mc;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 2'b00;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction on one port; the bench plays the memory, acking each
    // refill word after 'stall' idle cycles. Cycle 0 is the IDLE cycle in
    // which req is first sampled.
    task automatic run_txn(input int port, input logic [31:0] a, input int stall,
                           input logic exp_hit, input int exp_lat, input int exp_words);
        int         cyc;
        int         words;
        int         sc;
        bit         seen;
        bit         addr_bad;
        logic [1:0] g;
        logic       h;
        @(negedge clk);
        if (port == 0) addr0 = a;
        else           addr1 = a;
        req[port] = 1'b1;
        cyc = 0; words = 0; sc = 0; seen = 0; addr_bad = 0; g = 2'b00; h = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                if (mem_addr !== {a[31:4], words[3:0]}) addr_bad = 1'b1;
                if (sc < stall) begin
                    mem_ack = 1'b0;
                    sc++;
                end else begin
                    mem_ack = 1'b1;
                    sc = 0;
                    words++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (done) begin
                seen      = 1'b1;
                g         = grant;
                h         = hit;
                req[port] = 1'b0;
            end
        end
        mem_ack = 1'b0;
        check("txn_done_seen", seen, 1);
        check("txn_latency", cyc, exp_lat);
        check("txn_hit", h, exp_hit);
        check("txn_grant", g, (port == 1) ? 2'b10 : 2'b01);
        check("txn_refill_words", words, exp_words);
        check("txn_mem_addr_ok", addr_bad, 0);
    endtask

    initial begin
        int          cyc;
        int          nd;
        int          words;
        logic [1:0]  g0;

        vecs[0] = '{0, 32'h0000_1234, 0, 1'b0, 18, 16, 32'd0, 32'd1};
        vecs[1] = '{0, 32'h0000_1238, 0, 1'b1,  2,  0, 32'd1, 32'd1};
        vecs[2] = '{1, 32'h0000_2230, 0, 1'b0, 18, 16, 32'd1, 32'd2};
        vecs[3] = '{0, 32'h0000_1230, 0, 1'b0, 18, 16, 32'd1, 32'd3};
        vecs[4] = '{1, 32'h0000_2230, 0, 1'b0, 18, 16, 32'd1, 32'd4};
        vecs[5] = '{1, 32'h0000_223F, 0, 1'b1,  2,  0, 32'd2, 32'd4};
        vecs[6] = '{0, 32'h8000_0005, 5, 1'b0, 98, 16, 32'd2, 32'd5};
        vecs[7] = '{1, 32'h8000_000A, 0, 1'b1,  2,  0, 32'd3, 32'd5};
        vecs[8] = '{1, 32'h0000_000A, 0, 1'b0, 18, 16, 32'd3, 32'd6};

        rst_n = 1'b0; req = 2'b00; addr0 = '0; addr1 = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        rst_n = 1'b1;

        // ---------------- table-driven transactions ----------------
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].port, vecs[i].addr, vecs[i].stall, vecs[i].exp_hit,
                    vecs[i].exp_lat, vecs[i].exp_words);
            @(negedge clk);
            check("vec_hit_count", hit_count, vecs[i].exp_hc);
            check("vec_miss_count", miss_count, vecs[i].exp_mc);
            check("vec_idle_busy", busy, 0);
            check("vec_idle_grant", grant, 2'b00);
        end

        // ---------------- round-robin, both ports resident ----------------
        // Port 1 was served last, so port 0 wins first.
        @(negedge clk);
        addr0 = 32'h0000_0003;
        addr1 = 32'h0000_2231;
        req   = 2'b11;
        cyc = 0; nd = 0;
        while (nd < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                check("rr_grant", grant, (nd % 2 == 0) ? 2'b01 : 2'b10);
                check("rr_hit", hit, 1);
                check("rr_done_cycle", cyc, 2 + 3 * nd);
                nd++;
                if (nd == 4) req = 2'b00;
            end
        end
        check("rr_done_count", nd, 4);
        @(negedge clk);
        check("rr_hit_count", hit_count, 7);
        check("rr_miss_count", miss_count, 6);

        // ---------------- reset in the middle of a refill ----------------
        @(negedge clk);
        addr0 = 32'h0000_9990;
        req   = 2'b01;
        cyc = 0; words = 0;
        while (words < 7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                mem_ack = 1'b1;
                words++;
            end else begin
                mem_ack = 1'b0;
            end
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
        #1;
        check("mid_refill_mem_req", mem_req, 1);
        check("mid_refill_mem_addr", mem_addr, 32'h0000_9997);
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_mem_addr", mem_addr, 0);
        check("async_rst_hit_count", hit_count, 0);
        check("async_rst_miss_count", miss_count, 0);
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 32'h0000_9990, 0, 1'b0, 18, 16);
        @(negedge clk);
        check("reissue_miss_count", miss_count, 1);
        check("reissue_hit_count", hit_count, 0);

        // ---------------- same-line contention on a cold cache ----------------
        do_reset();
        @(negedge clk);
        addr0 = 32'h0000_5671;
        addr1 = 32'h0000_567C;
        req   = 2'b11;
        cyc = 0; nd = 0; g0 = 2'b00;
        while (nd < 2 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            mem_ack = mem_req;
            if (done) begin
                g0 = grant;
                if (nd == 0) begin
                    check("same_line_first_grant", g0, 2'b01);
                    check("same_line_first_hit", hit, 0);
                    check("same_line_first_cycle", cyc, 18);
                    req[0] = 1'b0;
                end else begin
                    check("same_line_second_grant", g0, 2'b10);
                    check("same_line_second_hit", hit, 1);
                    check("same_line_second_cycle", cyc, 21);
                    req[1] = 1'b0;
                end
                nd++;
            end
        end
        mem_ack = 1'b0;
        check("same_line_done_count", nd, 2);
        @(negedge clk);
        check("same_line_miss_count", miss_count, 1);
        check("same_line_hit_count", hit_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Sequencing and arbitration controller for the direct-mapped cache: 256 lines × 16 words, 20-bit tag, word-granular addresses.
- Shares one cache port between two requesters (port 0 = instruction trace, port 1 = data trace) using round-robin arbitration.
- Performs tag lookup with per-line valid bits.
- On a miss, sequences a 16-word line refill over a word-by-word memory handshake.
- Maintains hit and miss counters.
- Sits between the trace drivers and the memory model.

Parameters:
- ADDR_W, 32, address width.
- INDEX_W, 8, line index width (addr[11:4]).
- OFFSET_W, 4, word-in-line width (addr[3:0]).
- TAG_W = ADDR_W-INDEX_W-OFFSET_W, 20, derived; not overridable.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 2: request per port; held high until that port sees done.
- addr0, input, ADDR_W: port 0 address; stable while req[0]=1.
- addr1, input, ADDR_W: port 1 address; stable while req[1]=1.
- grant, output, 2: one-hot owner of the current transaction; 0 when idle.
- done, output, 1: one-cycle pulse; transaction of the grant port is complete.
- hit, output, 1: valid with done; 1 = hit, 0 = miss that was refilled.
- busy, output, 1: state != IDLE.
- mem_req, output, 1: refill word request.
- mem_addr, output, ADDR_W: address of the refill word, {line_addr[31:4], word_cnt}.
- mem_ack, input, 1: the memory accepted or returned the current word.
- hit_count, output, 32: total hits; wraps modulo 2^32.
- miss_count, output, 32: total misses; wraps modulo 2^32.

Behaviour:
- Reset (async, rst_n=0):
  - State → IDLE.
  - grant, done, hit, busy, mem_req = 0.
  - mem_addr = 0.
  - Both counters = 0.
  - All 256 valid bits cleared.
  - RR pointer = port 1, so port 0 wins the first contention.
  - Reset mid-refill aborts immediately: mem_req falls asynchronously, and tag/valid for the line are NOT written.
- States: IDLE, LOOKUP, REFILL, RESPOND.
- IDLE:
  - If req != 0, pick the owner. With a single requester, that requester wins. With both, the port not served last wins.
  - Latch its address, set grant one-hot, go to LOOKUP.
  - No request: stay in IDLE with grant = 0.
- LOOKUP (1 cycle):
  - hit_int = valid[index] && tagArray[index]==tag.
  - hit_int=1 → RESPOND.
  - hit_int=0 → clear word_cnt, go to REFILL.
- REFILL:
  - mem_req=1, mem_addr={latched[31:4], word_cnt}.
  - Each cycle with mem_ack=1: word_cnt++.
  - mem_ack while word_cnt==15: write tagArray[index]=tag and valid[index]=1, deassert mem_req next cycle, go to RESPOND.
  - mem_ack=0 holds state, word_cnt and mem_addr with no timeout.
  - Exactly 16 acks per miss.
- RESPOND (1 cycle):
  - done=1, hit=hit_int, grant still asserted.
  - hit_count or miss_count increments by 1, visible the cycle after done.
  - RR pointer ← owner.
  - Go to IDLE, where grant clears.
- Latency, req sampled in IDLE at cycle 0:
  - Hit: done at cycle 2.
  - Miss with back-to-back acks: done at cycle 18.
  - Minimum spacing between done pulses is 3 cycles.
- Requester dropping req mid-transaction: the transaction still completes and counts; done is ignored by the requester.
- Both ports requesting the same line:
  - The first is served (miss + refill).
  - The second then hits.
- A new request arriving while busy waits.
  - The owning port must drop req the cycle after done, or it is re-arbitrated as a new request.
- Refill overwrites a valid line with a different tag (conflict eviction) unconditionally; there is no writeback.
- Counter wrap: 0xFFFFFFFF + 1 = 0, with no flag.

Test Plan:
- Cold miss then hit:
  - Stimulus: reset; port 0 addr 0x0000_1234; ack every cycle.
  - Required response: mem_addr runs 0x1230..0x123F; done at cycle 18 with hit=0; miss_count=1.
  - Follow-up: repeat with 0x0000_1238 → done at cycle 2, hit=1, hit_count=1.
- Conflict eviction:
  - Stimulus: 0x0000_1230, then 0x0000_2230 (same index 0x23, tag differs), then 0x0000_1230.
  - Required response: all three miss; miss_count=3; 48 acks total.
- Round-robin:
  - Stimulus: req=2'b11 held continuously, both ports on already-resident lines.
  - Required response: grant sequence 01,10,01,10; done every 3 cycles; hit_count=4 after 4 dones.
- Stalled memory:
  - Stimulus: miss with mem_ack low for 5 cycles before each word.
  - Required response: mem_addr stable while stalled; 16 words; done at cycle 2+16×6=98.
- Reset mid-refill:
  - Stimulus: assert rst_n=0 after 7 acks, then reissue the same address.
  - Required response: mem_req drops without waiting for clk; counters 0; the reissue misses again with a full 16-word refill.
- Same-line contention:
  - Stimulus: both ports request addresses within line 0x0000_5670 on a cold cache.
  - Required response: port 0 misses, port 1 hits; miss_count=1, hit_count=1.
